// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: word/address widths,
// opcode field bounds and the fetch state encoding.
package fetch_unit_pkg;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;
    localparam int OPC_HI      = 15;
    localparam int OPC_LO      = 11;
    localparam int OPC_W       = OPC_HI - OPC_LO + 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit_ret_stack.sv
// Small LIFO holding return addresses. The occupancy counter saturates at
// both ends, so full/empty are exact and the pointer never wraps.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] top_cnt;
    logic [IDX_W-1:0] top_idx;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign top_cnt = cnt - CNT_W'(1);
    assign top_idx = top_cnt[IDX_W-1:0];
    assign dout    = mem[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Storage carries data only; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[cnt[IDX_W-1:0]] <= din;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC, IR and the return stack, fetches words
// over a variable-latency req/ack handshake and applies jump/call/ret in IDLE.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int STACK_DEPTH = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_start,
    input  logic               jump,
    input  logic               call,
    input  logic               ret,
    input  logic [ADDR_W-1:0]  target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [INSTR_W-1:0] ir,
    output logic [OPC_W-1:0]   opcode,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               fetch_done,
    output logic               fetch_err,
    output logic               stk_ovf,
    output logic               stk_unf
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_t      state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cmd_ok;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] stk_dout;

    assign cmd_ok    = (state == IDLE);
    assign stk_push  = cmd_ok && call && !stk_full;
    assign stk_pop   = cmd_ok && !call && ret && !stk_empty;
    assign imem_addr = pc;
    assign busy      = (state == REQ);
    assign opcode    = ir[OPC_HI:OPC_LO];

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= '0;
            ir         <= '0;
            wait_cnt   <= '0;
            imem_req   <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            stk_ovf    <= 1'b0;
            stk_unf    <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                IDLE: begin
                    // PC command commits now so a same-cycle fetch uses the new PC.
                    if (call) begin
                        pc <= target;
                        if (stk_full) stk_ovf <= 1'b1;
                    end else if (ret) begin
                        if (stk_empty) stk_unf <= 1'b1;
                        else           pc      <= stk_dout;
                    end else if (jump) begin
                        pc <= target;
                    end
                    if (fetch_start) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        ir         <= imem_rdata;
                        pc         <= pc + ADDR_W'(1);
                        fetch_done <= 1'b1;
                        imem_req   <= 1'b0;
                        state      <= IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based reference model compared every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_fetch_unit;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;
    localparam int TMO     = 15;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               fetch_start = 1'b0;
    logic               jump = 1'b0;
    logic               call = 1'b0;
    logic               ret = 1'b0;
    logic [ADDR_W-1:0]  target = '0;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               imem_ack;
    logic [INSTR_W-1:0] ir;
    logic [4:0]         opcode;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               fetch_done;
    logic               fetch_err;
    logic               stk_ovf;
    logic               stk_unf;

    logic auto_ack = 1'b0;
    logic man_ack  = 1'b0;
    assign imem_ack = auto_ack | man_ack;

    int checks = 0;
    int errors = 0;
    int ack_lat = -1;
    int req_cnt = 0;
    int busy_cycles = 0;
    int done_pulses = 0;

    fetch_unit #(
        .ADDR_W      (ADDR_W),
        .INSTR_W     (INSTR_W),
        .STACK_DEPTH (DEPTH),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .jump        (jump),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .ir          (ir),
        .opcode      (opcode),
        .pc          (pc),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .fetch_err   (fetch_err),
        .stk_ovf     (stk_ovf),
        .stk_unf     (stk_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: what the fetch stage must hold after each edge.
    logic [ADDR_W-1:0]  m_pc;
    logic [INSTR_W-1:0] m_ir;
    logic [ADDR_W-1:0]  m_stk[$];
    bit m_fetching, m_done, m_err, m_ovf, m_unf;
    int m_wait;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = '0; m_ir = '0; m_stk.delete();
            m_fetching = 0; m_done = 0; m_err = 0; m_ovf = 0; m_unf = 0; m_wait = 0;
        end else begin
            m_done = 0;
            if (m_fetching) begin
                if (imem_ack) begin
                    m_ir = imem_rdata;
                    m_pc = m_pc + 8'd1;
                    m_done = 1;
                    m_fetching = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_err = 1;
                        m_fetching = 0;
                    end
                end
            end else begin
                if (call) begin
                    if (m_stk.size() == DEPTH) m_ovf = 1;
                    else m_stk.push_back(m_pc);
                    m_pc = target;
                end else if (ret) begin
                    if (m_stk.size() == 0) m_unf = 1;
                    else m_pc = m_stk.pop_back();
                end else if (jump) begin
                    m_pc = target;
                end
                if (fetch_start) begin
                    m_fetching = 1;
                    m_wait = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("pc", 32'(pc), 32'(m_pc));
        chk("ir", 32'(ir), 32'(m_ir));
        chk("opcode", 32'(opcode), 32'(m_ir[15:11]));
        chk("imem_req", 32'(imem_req), 32'(m_fetching));
        chk("busy", 32'(busy), 32'(m_fetching));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("fetch_done", 32'(fetch_done), 32'(m_done));
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        chk("stk_ovf", 32'(stk_ovf), 32'(m_ovf));
        chk("stk_unf", 32'(stk_unf), 32'(m_unf));
        if (busy === 1'b1) busy_cycles++;
        if (fetch_done === 1'b1) done_pulses++;
    end

    // Memory responder: ack arrives ack_lat cycles after the request rises.
    always @(posedge clk) begin
        #1;
        if (imem_req === 1'b1) begin
            auto_ack = (req_cnt == ack_lat);
            req_cnt++;
        end else begin
            auto_ack = 1'b0;
            req_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic fs, input logic j, input logic c, input logic r,
                          input logic [ADDR_W-1:0] tgt);
        fetch_start = fs; jump = j; call = c; ret = r; target = tgt;
        tick();
        fetch_start = 0; jump = 0; call = 0; ret = 0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            tick();
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic do_fetch(input int lat, input logic [INSTR_W-1:0] data);
        ack_lat = lat;
        imem_rdata = data;
        strobe(1, 0, 0, 0, '0);
        wait_idle("fetch_end");
    endtask

    initial begin
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_flags", {29'd0, fetch_err, stk_ovf, stk_unf}, 32'h0);

        // Scenario 1: ack three cycles after request.
        busy_cycles = 0; done_pulses = 0;
        do_fetch(3, 16'h3A05);
        tick();
        chk("t1_ir", 32'(ir), 32'h3A05);
        chk("t1_opcode", 32'(opcode), 32'h07);
        chk("t1_pc", 32'(pc), 32'h01);
        chk("t1_busy_cycles", 32'(busy_cycles), 32'd4);
        chk("t1_done_pulses", 32'(done_pulses), 32'd1);

        // Scenario 2: call from pc=5, fetch at target, return.
        strobe(0, 1, 0, 0, 8'h05);
        strobe(0, 0, 1, 0, 8'h40);
        chk("t2_call_pc", 32'(pc), 32'h40);
        do_fetch(0, 16'h1234);
        chk("t2_fetch_pc", 32'(pc), 32'h41);
        strobe(0, 0, 0, 1, '0);
        chk("t2_ret_pc", 32'(pc), 32'h05);
        chk("t2_flags", {30'd0, stk_ovf, stk_unf}, 32'h0);

        // Scenario 3: overflow then LIFO unwinding then underflow.
        strobe(0, 0, 1, 0, 8'h10);
        strobe(0, 0, 1, 0, 8'h20);
        strobe(0, 0, 1, 0, 8'h30);
        strobe(0, 0, 1, 0, 8'h40);
        chk("t3_no_ovf_yet", 32'(stk_ovf), 32'h0);
        strobe(0, 0, 1, 0, 8'h50);
        chk("t3_ovf", 32'(stk_ovf), 32'h1);
        chk("t3_ovf_pc", 32'(pc), 32'h50);
        strobe(0, 0, 0, 1, '0); chk("t3_ret1", 32'(pc), 32'h30);
        strobe(0, 0, 0, 1, '0); chk("t3_ret2", 32'(pc), 32'h20);
        strobe(0, 0, 0, 1, '0); chk("t3_ret3", 32'(pc), 32'h10);
        strobe(0, 0, 0, 1, '0); chk("t3_ret4", 32'(pc), 32'h05);
        chk("t3_no_unf_yet", 32'(stk_unf), 32'h0);
        strobe(0, 0, 0, 1, '0);
        chk("t3_unf", 32'(stk_unf), 32'h1);
        chk("t3_unf_pc", 32'(pc), 32'h05);

        // Scenario 4: jump and fetch in one cycle, then PC wraps.
        ack_lat = 1;
        imem_rdata = 16'hF00D;
        strobe(1, 1, 0, 0, 8'hFF);
        chk("t4_req", 32'(imem_req), 32'h1);
        chk("t4_addr", 32'(imem_addr), 32'hFF);
        wait_idle("t4_end");
        chk("t4_wrap_pc", 32'(pc), 32'h00);
        chk("t4_ir", 32'(ir), 32'hF00D);

        // Scenario 5: no ack, commands during REQ are ignored.
        busy_cycles = 0;
        ack_lat = -1;
        strobe(1, 0, 0, 0, '0);
        strobe(0, 1, 1, 1, 8'h77);
        wait_idle("t5_end");
        chk("t5_err", 32'(fetch_err), 32'h1);
        chk("t5_busy_cycles", 32'(busy_cycles), 32'(TMO));
        chk("t5_pc", 32'(pc), 32'h00);
        chk("t5_ir", 32'(ir), 32'hF00D);
        chk("t5_ovf_kept", 32'(stk_ovf), 32'h1);

        // Scenario 6: reset in the middle of a request, late ack ignored.
        strobe(0, 1, 0, 0, 8'h22);
        strobe(1, 0, 0, 0, '0);
        tick();
        chk("t6_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_req_async", 32'(imem_req), 32'h0);
        chk("t6_pc_async", 32'(pc), 32'h0);
        chk("t6_ir_async", 32'(ir), 32'h0);
        man_ack = 1'b1;
        imem_rdata = 16'hBEEF;
        tick();
        rst = 1'b0;
        tick();
        man_ack = 1'b0;
        tick();
        chk("t6_ir_after", 32'(ir), 32'h0);
        chk("t6_pc_after", 32'(pc), 32'h0);
        chk("t6_flags_cleared", {29'd0, fetch_err, stk_ovf, stk_unf}, 32'h0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the microcoded control unit.
- Owns PC, IR and a small hardware return-address stack.
- Fetches 16-bit instruction words from instruction memory over a req/ack handshake with variable latency.
- Presents opcode = ir[15:11] to the control unit and applies jump/call/ret PC updates when the control unit strobes them.

Parameters:
- ADDR_W, 8, PC / instruction address width in bits.
- INSTR_W, 16, instruction word width.
- STACK_DEPTH, 4, return-stack entries (power of two).
- TIMEOUT, 15, maximum wait cycles for imem_ack before the fetch is aborted.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- fetch_start  in  1  control-unit strobe: fetch the word at the current PC.
- jump  in  1  strobe: PC <= target.
- call  in  1  strobe: push PC, then PC <= target.
- ret  in  1  strobe: PC <= popped address.
- target  in  ADDR_W  jump/call destination, from the datapath immediate.
- imem_req  out  1  memory request.
- imem_addr  out  ADDR_W  memory address; equals pc.
- imem_rdata  in  INSTR_W  memory read data, valid with imem_ack.
- imem_ack  in  1  memory completion, single-cycle.
- ir  out  INSTR_W  instruction register.
- opcode  out  5  ir[15:11], combinational from ir.
- pc  out  ADDR_W  program counter.
- busy  out  1  high in REQ state.
- fetch_done  out  1  one-cycle pulse when ir is updated.
- fetch_err  out  1  sticky: timeout occurred.
- stk_ovf  out  1  sticky: push attempted while stack full.
- stk_unf  out  1  sticky: pop attempted while stack empty.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - pc=0, ir=0, state=IDLE.
  - Stack empty, all sticky flags 0.
  - imem_req=0, fetch_done=0.
- State machine:
  - IDLE:
    - fetch_start -> REQ; wait counter cleared.
    - Otherwise stay in IDLE.
  - REQ:
    - imem_req=1, imem_addr=pc.
    - On imem_ack: ir <= imem_rdata, pc <= pc+1 mod 2^ADDR_W, fetch_done=1 next cycle, -> IDLE.
    - No ack: counter increments. When the counter reaches TIMEOUT with no ack: fetch_err <= 1, ir and pc unchanged, -> IDLE.
- Latency:
  - Minimum fetch is 2 cycles: fetch_start in cycle N, req in N+1, ack in N+1, fetch_done in N+2.
  - imem_req drops in the cycle after ack.
- PC commands (jump/call/ret):
  - Accepted only in IDLE; ignored while busy.
  - If more than one strobe is high, priority is call > ret > jump.
  - jump: pc <= target.
  - call:
    - Not full: push pc, i.e. the already-incremented return address; pc <= target.
    - Full: no push, stk_ovf <= 1, pc <= target anyway.
  - ret:
    - Not empty: pc <= top entry, pop.
    - Empty: pc unchanged, stk_unf <= 1.
- Command and fetch_start in the same cycle:
  - The PC update commits at that edge; REQ starts next cycle.
  - The fetch therefore uses the new PC. This supports control-unit microcode that issues jump+fetch in one microinstruction.
- Wrap-around:
  - pc = 2^ADDR_W-1 plus a fetch gives pc = 0; no flag.
  - Stack pointer never wraps; full/empty are exact.
- Errors: sticky flags are cleared only by rst.
- Reset mid-fetch: returns to IDLE immediately, imem_req deasserts asynchronously, and a late ack is ignored.
- opcode tracks ir with no additional latency.

Decomposition:
- Shared constants (existing constants.v): INSTR_W, ADDR_W, opcode field bounds (15:11), fetch state encodings IDLE=0 and REQ=1.
- Sub-module ret_stack (lifo):
  - Inputs: clk, rst, push, pop, din.
  - Outputs: dout, full, empty.
  - Parameters: DEPTH, WIDTH.
- Everything else lives in fetch_unit.

Test Plan:
1. Reset then fetch_start, with ack returned 3 cycles after req and rdata=16'h3A05 -> ir=3A05, opcode=5'b00111, pc=1, fetch_done one pulse, busy high 4 cycles.
2. call target=8'h40 at pc=5, fetch, then ret -> stack holds 5; after ret pc=5, stk_ovf=stk_unf=0.
3. Five calls with STACK_DEPTH=4 -> fifth sets stk_ovf=1 and pc=target; four rets restore the correct addresses in LIFO order; a fifth ret sets stk_unf=1 with pc unchanged.
4. jump target=8'hFF plus fetch_start in the same cycle -> imem_addr=FF in REQ; after ack pc=00 (wrap).
5. No ack for TIMEOUT cycles -> fetch_err=1, returns to IDLE, ir and pc unchanged; jump/call/ret pulsed during REQ are ignored.
6. rst asserted mid-REQ, then ack arrives -> ir stays 0, pc=0, imem_req=0 in the same cycle as rst.
